axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Sequential two-master AXI4 read-channel arbiter. Shares the core's single AR/R master port between the instruction-fetch (IF) and load/store (MEM) requesters.
- Replaces mux steering by WB-select signals with a registered grant that is held for the full transaction, including bursts.
- Sits between the IF/MEM AXI request logic and the core's AXI bridge.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, read data width
- LEN_W, 8, AXI burst length width
- RESP_W, 2, AXI response width
- MEM_STREAK, 4, max consecutive MEM grants while IF waits (range 1..15)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_ar_valid / if_ar_addr / if_ar_len / if_ar_size  in  1/ADDR_W/LEN_W/2  IF read request
- if_ar_ready  out  1  IF address accepted
- if_r_valid / if_r_data / if_r_resp / if_r_last  out  1/DATA_W/RESP_W/1  IF read beat
- if_r_ready  in  1  IF accepts beat
- mem_ar_valid / mem_ar_addr / mem_ar_len / mem_ar_size  in  same widths as IF  MEM read request
- mem_ar_ready  out  1  MEM address accepted
- mem_r_valid / mem_r_data / mem_r_resp / mem_r_last  out  same widths as IF  MEM read beat
- mem_r_ready  in  1  MEM accepts beat
- ar_valid / ar_addr / ar_len / ar_size  out  1/ADDR_W/LEN_W/2  to bridge
- ar_ready  in  1  bridge accepts address
- r_valid / r_data / r_resp / r_last  in  1/DATA_W/RESP_W/1  from bridge
- r_ready  out  1  to bridge
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, owner MEM, streak 0. All valid/ready outputs 0; ar_addr/len/size 0; busy 0. Reset asserted mid-burst aborts immediately. The bridge is reset on the same rst_n.
- FSM states: IDLE, ADDR, DATA.
- IDLE: arbitrate on the registered-cycle request inputs.
  - MEM wins when both valid, unless streak == MEM_STREAK and if_ar_valid, in which case IF wins.
  - Winner latched into owner; state goes to ADDR on the next edge.
  - Grant takes 1 cycle: ar_valid rises the cycle after the request is first seen.
  - Neither valid: stay IDLE.
- ADDR: ar_valid = owner's ar_valid. ar_addr/len/size are muxed from the owner (combinational, owner-registered select).
  - Owner's ar_ready = ar_ready; non-owner's ar_ready = 0.
  - On ar_valid & ar_ready, go to DATA.
  - Owner dropping ar_valid before the handshake is an AXI violation; a checker flags it and the design does not handle it.
- DATA: r_* are routed to the owner; r_ready = owner's r_ready.
  - Non-owner sees r_valid = 0, with data/resp/last driven 0.
  - On r_valid & r_ready & r_last, go to IDLE. A new grant is possible the following cycle; no same-cycle re-grant.
- Streak counter (4 bits):
  - Increments on each MEM grant made while if_ar_valid = 1.
  - Clears on any IF grant, or on a MEM grant with if_ar_valid = 0.
  - Saturates at MEM_STREAK.
- Responses: SLVERR/DECERR are forwarded unchanged. The arbiter never aborts a burst and always waits for r_last.
- Beat count: ar_len+1 beats is expected. The arbiter relies solely on r_last; an internal beat counter cross-check is an assertion only.
- Simultaneous events: a request arriving while not IDLE waits, held by the requester. In IDLE with both valid and streak below the limit, MEM is granted.
- No outputs are combinationally dependent on requester valid in IDLE: ar_valid = 0 in IDLE.

Decomposition:
- Shared AXI package holds:
  - AXI width constants (ADDR/DATA/LEN/RESP)
  - RESP encodings OKAY/EXOKAY/SLVERR/DECERR
  - owner enum {OWN_IF, OWN_MEM}
  - FSM state enum {IDLE, ADDR, DATA}
- One sub-module is natural: axi_rd_arb_pick, the combinational grant chooser. It takes if_valid, mem_valid and streak_at_limit and returns the winner.

Test Plan:
- Single IF read, len=0, addr 0x8000_0000: ar_valid rises 1 cycle after if_ar_valid, ar_ready at +2, r beat data 0x1122_3344_5566_7788 with last → if_r_valid 1 cycle, mem_r_valid stays 0, IDLE next cycle.
- IF and MEM valid in the same cycle, streak 0: MEM granted; IF granted only after the MEM r_last handshake, earliest 1 cycle later.
- MEM burst len=3 with r_ready toggling 1,0,1,1,1: exactly 4 beats are delivered to MEM. State stays DATA until the 4th beat with last. IF is held off (if_ar_ready = 0) throughout.
- MEM continuously valid and IF continuously valid, MEM_STREAK=4: grant order is MEM×4, IF, MEM×4, IF.
- SLVERR on the last beat of an IF burst: if_r_resp = 2'b10 is forwarded and the arbiter returns to IDLE normally.
- rst_n pulled low during DATA beat 2 of a len=7 burst: all valid outputs drop asynchronously and busy = 0. After release the first request is serviced normally.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI read-channel definitions for the two-master read arbiter:
// width constants, response encodings, owner and FSM state types.
package axi_rd_arbiter_pkg;

    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_RESP_W = 2;

    // Streak counter is four bits, so the MEM streak limit tops out at 15.
    localparam int STREAK_W = 4;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/axi_rd_arb_pick.sv
// Combinational grant chooser: MEM wins ties unless it has used up its
// streak while IF is waiting, in which case IF is served.
module axi_rd_arb_pick
    import axi_rd_arbiter_pkg::*;
(
    input  logic   if_valid,
    input  logic   mem_valid,
    input  logic   streak_at_limit,
    output logic   grant,
    output owner_t winner
);

    // Pick the winner among the currently valid requesters.
    always_comb begin
        grant  = if_valid | mem_valid;
        winner = OWN_MEM;
        if (if_valid && (!mem_valid || streak_at_limit)) begin
            winner = OWN_IF;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter sharing one AR/R port between the
// instruction-fetch (IF) and load/store (MEM) requesters. The grant is
// registered in IDLE and held for the whole transaction, including every
// beat of a burst, until the beat carrying r_last is accepted.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W     = AXI_ADDR_W,
    parameter int DATA_W     = AXI_DATA_W,
    parameter int LEN_W      = AXI_LEN_W,
    parameter int RESP_W     = AXI_RESP_W,
    parameter int MEM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_ar_valid,
    input  logic [ADDR_W-1:0] if_ar_addr,
    input  logic [LEN_W-1:0]  if_ar_len,
    input  logic [1:0]        if_ar_size,
    output logic              if_ar_ready,
    output logic              if_r_valid,
    output logic [DATA_W-1:0] if_r_data,
    output logic [RESP_W-1:0] if_r_resp,
    output logic              if_r_last,
    input  logic              if_r_ready,

    input  logic              mem_ar_valid,
    input  logic [ADDR_W-1:0] mem_ar_addr,
    input  logic [LEN_W-1:0]  mem_ar_len,
    input  logic [1:0]        mem_ar_size,
    output logic              mem_ar_ready,
    output logic              mem_r_valid,
    output logic [DATA_W-1:0] mem_r_data,
    output logic [RESP_W-1:0] mem_r_resp,
    output logic              mem_r_last,
    input  logic              mem_r_ready,

    output logic              ar_valid,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [LEN_W-1:0]  ar_len,
    output logic [1:0]        ar_size,
    input  logic              ar_ready,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    input  logic [RESP_W-1:0] r_resp,
    input  logic              r_last,
    output logic              r_ready,

    output logic              busy
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MEM_STREAK);

    state_t              state;
    owner_t              owner;
    logic [STREAK_W-1:0] streak;

    logic   pick_grant;
    owner_t pick_owner;
    logic   streak_at_limit;
    logic   in_addr;
    logic   in_data;
    logic   own_if;
    logic   ar_hs;
    logic   r_hs;
    logic   r_done;

    assign streak_at_limit = (streak == STREAK_MAX);
    assign in_addr         = (state == ADDR);
    assign in_data         = (state == DATA);
    assign own_if          = (owner == OWN_IF);
    assign ar_hs           = ar_valid & ar_ready;
    assign r_hs            = in_data & r_valid & r_ready;
    assign r_done          = r_hs & r_last;
    assign busy            = (state != IDLE);

    axi_rd_arb_pick u_pick (
        .if_valid        (if_ar_valid),
        .mem_valid       (mem_ar_valid),
        .streak_at_limit (streak_at_limit),
        .grant           (pick_grant),
        .winner          (pick_owner)
    );

    // Address channel: only the registered owner reaches the bridge, and only in ADDR.
    always_comb begin
        ar_valid     = 1'b0;
        ar_addr      = '0;
        ar_len       = '0;
        ar_size      = '0;
        if_ar_ready  = 1'b0;
        mem_ar_ready = 1'b0;
        if (in_addr) begin
            if (own_if) begin
                ar_valid    = if_ar_valid;
                ar_addr     = if_ar_addr;
                ar_len      = if_ar_len;
                ar_size     = if_ar_size;
                if_ar_ready = ar_ready;
            end else begin
                ar_valid     = mem_ar_valid;
                ar_addr      = mem_ar_addr;
                ar_len       = mem_ar_len;
                ar_size      = mem_ar_size;
                mem_ar_ready = ar_ready;
            end
        end
    end

    // Read data channel: beats go to the owner only; the other side sees zeros.
    always_comb begin
        r_ready     = 1'b0;
        if_r_valid  = 1'b0;
        if_r_data   = '0;
        if_r_resp   = '0;
        if_r_last   = 1'b0;
        mem_r_valid = 1'b0;
        mem_r_data  = '0;
        mem_r_resp  = '0;
        mem_r_last  = 1'b0;
        if (in_data) begin
            if (own_if) begin
                r_ready    = if_r_ready;
                if_r_valid = r_valid;
                if_r_data  = r_data;
                if_r_resp  = r_resp;
                if_r_last  = r_last;
            end else begin
                r_ready     = mem_r_ready;
                mem_r_valid = r_valid;
                mem_r_data  = r_data;
                mem_r_resp  = r_resp;
                mem_r_last  = r_last;
            end
        end
    end

    // Arbitration FSM with owner and MEM-streak tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= OWN_MEM;
            streak <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_grant) begin
                        owner <= pick_owner;
                        state <= ADDR;
                        // Only MEM grants that made IF wait extend the streak.
                        if (pick_owner == OWN_MEM && if_ar_valid) begin
                            if (!streak_at_limit) begin
                                streak <= streak + STREAK_W'(1);
                            end
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (r_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat tracking used only to cross-check r_last against the granted length.
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] exp_len;

    // Capture the burst length at the address handshake and count accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            exp_len  <= '0;
        end else if (ar_hs) begin
            beat_cnt <= '0;
            exp_len  <= ar_len;
        end else if (r_hs) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
        end
    end

    a_last_on_final_beat: assert property (@(posedge clk) disable iff (!rst_n)
        r_done |-> (beat_cnt == exp_len));

    a_owner_holds_ar_valid: assert property (@(posedge clk) disable iff (!rst_n)
        in_addr |-> ar_valid);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for the two-master AXI read arbiter.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        if_ar_valid;
    logic [63:0] if_ar_addr;
    logic [7:0]  if_ar_len;
    logic [1:0]  if_ar_size;
    logic        if_ar_ready;
    logic        if_r_valid;
    logic [63:0] if_r_data;
    logic [1:0]  if_r_resp;
    logic        if_r_last;
    logic        if_r_ready;
    logic        mem_ar_valid;
    logic [63:0] mem_ar_addr;
    logic [7:0]  mem_ar_len;
    logic [1:0]  mem_ar_size;
    logic        mem_ar_ready;
    logic        mem_r_valid;
    logic [63:0] mem_r_data;
    logic [1:0]  mem_r_resp;
    logic        mem_r_last;
    logic        mem_r_ready;
    logic        ar_valid;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic [1:0]  ar_size;
    logic        ar_ready;
    logic        r_valid;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_ready;
    logic        busy;

    int total;
    int bad;

    axi_rd_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_ar_valid  (if_ar_valid),
        .if_ar_addr   (if_ar_addr),
        .if_ar_len    (if_ar_len),
        .if_ar_size   (if_ar_size),
        .if_ar_ready  (if_ar_ready),
        .if_r_valid   (if_r_valid),
        .if_r_data    (if_r_data),
        .if_r_resp    (if_r_resp),
        .if_r_last    (if_r_last),
        .if_r_ready   (if_r_ready),
        .mem_ar_valid (mem_ar_valid),
        .mem_ar_addr  (mem_ar_addr),
        .mem_ar_len   (mem_ar_len),
        .mem_ar_size  (mem_ar_size),
        .mem_ar_ready (mem_ar_ready),
        .mem_r_valid  (mem_r_valid),
        .mem_r_data   (mem_r_data),
        .mem_r_resp   (mem_r_resp),
        .mem_r_last   (mem_r_last),
        .mem_r_ready  (mem_r_ready),
        .ar_valid     (ar_valid),
        .ar_addr      (ar_addr),
        .ar_len       (ar_len),
        .ar_size      (ar_size),
        .ar_ready     (ar_ready),
        .r_valid      (r_valid),
        .r_data       (r_data),
        .r_resp       (r_resp),
        .r_last       (r_last),
        .r_ready      (r_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        if_ar_valid  = 1'b0; if_ar_addr  = '0; if_ar_len  = '0; if_ar_size  = '0; if_r_ready  = 1'b0;
        mem_ar_valid = 1'b0; mem_ar_addr = '0; mem_ar_len = '0; mem_ar_size = '0; mem_r_ready = 1'b0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        r_valid = 1'b1; r_last = 1'b1; r_data = 64'hFFFF_0000_FFFF_0000;
        if_ar_valid = 1'b1; mem_ar_valid = 1'b1;
        @(negedge clk); #1;
        total++;
        if ({ar_valid, if_ar_ready, mem_ar_ready, if_r_valid, mem_r_valid, r_ready, busy} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {ar_valid, if_ar_ready, mem_ar_ready, if_r_valid, mem_r_valid, r_ready, busy});
        end
        total++;
        if ({ar_addr, ar_len, ar_size, if_r_data, mem_r_data} !== '0) begin
            bad++;
            $display("FAIL reset_data: ar_addr=%h ar_len=%h ar_size=%h if_r_data=%h mem_r_data=%h want all 0",
                     ar_addr, ar_len, ar_size, if_r_data, mem_r_data);
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++;
        if ({ar_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL reset_release_idle: ar_valid,busy=%b want 00", {ar_valid, busy});
        end
    endtask

    task automatic test_single_if();
        @(negedge clk);
        if_ar_valid = 1'b1; if_ar_addr = 64'h8000_0000; if_ar_len = 8'd0; if_ar_size = 2'd3;
        #1;
        total++;
        if (ar_valid !== 1'b0) begin
            bad++; $display("FAIL single_if_same_cycle: ar_valid=%b want 0", ar_valid);
        end
        @(negedge clk); #1;
        total++;
        if ({ar_valid, ar_addr, ar_len, ar_size, if_ar_ready, busy} !== {1'b1, 64'h8000_0000, 8'd0, 2'd3, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL single_if_grant: ar_valid=%b ar_addr=%h ar_len=%h ar_size=%h if_ar_ready=%b busy=%b want 1 80000000 0 3 0 1",
                     ar_valid, ar_addr, ar_len, ar_size, if_ar_ready, busy);
        end
        @(negedge clk);
        ar_ready = 1'b1;
        #1;
        total++;
        if ({if_ar_ready, mem_ar_ready} !== 2'b10) begin
            bad++; $display("FAIL single_if_ar_ready: if,mem=%b want 10", {if_ar_ready, mem_ar_ready});
        end
        @(negedge clk);
        ar_ready = 1'b0; if_ar_valid = 1'b0;
        r_valid = 1'b1; r_data = 64'h1122_3344_5566_7788; r_resp = RESP_OKAY; r_last = 1'b1; if_r_ready = 1'b1;
        #1;
        total++;
        if ({if_r_valid, if_r_data, if_r_last, r_ready} !== {1'b1, 64'h1122_3344_5566_7788, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL single_if_beat: if_r_valid=%b if_r_data=%h if_r_last=%b r_ready=%b want 1 1122334455667788 1 1",
                     if_r_valid, if_r_data, if_r_last, r_ready);
        end
        total++;
        if ({mem_r_valid, mem_r_data} !== 65'd0) begin
            bad++; $display("FAIL single_if_mem_quiet: mem_r_valid=%b mem_r_data=%h want 0 0", mem_r_valid, mem_r_data);
        end
        @(negedge clk);
        r_valid = 1'b0; r_last = 1'b0; r_data = '0; if_r_ready = 1'b0;
        #1;
        total++;
        if ({busy, if_r_valid, ar_valid} !== 3'b000) begin
            bad++; $display("FAIL single_if_back_idle: busy,if_r_valid,ar_valid=%b want 000", {busy, if_r_valid, ar_valid});
        end
    endtask

    task automatic test_both_same_cycle();
        @(negedge clk);
        if_ar_valid  = 1'b1; if_ar_addr  = 64'h1000; if_ar_len  = 8'd0;
        mem_ar_valid = 1'b1; mem_ar_addr = 64'h2000; mem_ar_len = 8'd0;
        @(negedge clk); #1;
        total++;
        if ({ar_valid, ar_addr} !== {1'b1, 64'h2000}) begin
            bad++; $display("FAIL both_mem_first: ar_valid=%b ar_addr=%h want 1 2000", ar_valid, ar_addr);
        end
        ar_ready = 1'b1;
        #1;
        total++;
        if ({if_ar_ready, mem_ar_ready} !== 2'b01) begin
            bad++; $display("FAIL both_ar_ready_route: if,mem=%b want 01", {if_ar_ready, mem_ar_ready});
        end
        @(negedge clk);
        ar_ready = 1'b0; mem_ar_valid = 1'b0;
        r_valid = 1'b1; r_data = 64'hA5A5; r_last = 1'b1; mem_r_ready = 1'b1; if_r_ready = 1'b1;
        #1;
        total++;
        if ({mem_r_valid, mem_r_data, if_r_valid, if_r_data} !== {1'b1, 64'hA5A5, 1'b0, 64'h0}) begin
            bad++;
            $display("FAIL both_mem_beat: mem_r_valid=%b mem_r_data=%h if_r_valid=%b if_r_data=%h want 1 a5a5 0 0",
                     mem_r_valid, mem_r_data, if_r_valid, if_r_data);
        end
        @(negedge clk);
        r_valid = 1'b0; r_last = 1'b0;
        #1;
        total++;
        if ({ar_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL both_no_same_cycle_regrant: ar_valid,busy=%b want 00", {ar_valid, busy});
        end
        @(negedge clk); #1;
        total++;
        if ({ar_valid, ar_addr} !== {1'b1, 64'h1000}) begin
            bad++; $display("FAIL both_if_second: ar_valid=%b ar_addr=%h want 1 1000", ar_valid, ar_addr);
        end
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0; if_ar_valid = 1'b0;
        r_valid = 1'b1; r_data = 64'h5A5A; r_last = 1'b1;
        #1;
        total++;
        if ({if_r_valid, if_r_data, mem_r_valid} !== {1'b1, 64'h5A5A, 1'b0}) begin
            bad++;
            $display("FAIL both_if_beat: if_r_valid=%b if_r_data=%h mem_r_valid=%b want 1 5a5a 0", if_r_valid, if_r_data, mem_r_valid);
        end
        @(negedge clk);
        r_valid = 1'b0; r_last = 1'b0; mem_r_ready = 1'b0; if_r_ready = 1'b0;
    endtask

    task automatic test_mem_burst();
        logic [63:0] beat_data [4];
        logic        rdy_pat   [5];
        int          k;
        int          delivered;
        int          held_bad;
        beat_data[0] = 64'h0000_0000_0000_0A00; beat_data[1] = 64'h0000_0000_0000_0A01;
        beat_data[2] = 64'h0000_0000_0000_0A02; beat_data[3] = 64'h0000_0000_0000_0A03;
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b1; rdy_pat[3] = 1'b1; rdy_pat[4] = 1'b1;
        k = 0; delivered = 0; held_bad = 0;
        @(negedge clk);
        mem_ar_valid = 1'b1; mem_ar_addr = 64'h3000; mem_ar_len = 8'd3; mem_ar_size = 2'd3;
        @(negedge clk);
        if_ar_valid = 1'b1; if_ar_addr = 64'h4000; if_ar_len = 8'd0;
        ar_ready = 1'b1;
        #1;
        total++;
        if ({ar_len, mem_ar_ready, if_ar_ready} !== {8'd3, 1'b1, 1'b0}) begin
            bad++; $display("FAIL burst_addr: ar_len=%h mem_ar_ready=%b if_ar_ready=%b want 3 1 0", ar_len, mem_ar_ready, if_ar_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ar_ready = 1'b0; mem_ar_valid = 1'b0;
            r_valid = 1'b1; r_data = beat_data[k]; r_last = (k == 3);
            r_resp = (k == 1) ? RESP_EXOKAY : RESP_OKAY;
            mem_r_ready = rdy_pat[c];
            #1;
            total++;
            if ({mem_r_valid, mem_r_data, mem_r_last, r_ready} !== {1'b1, beat_data[k], (k == 3), rdy_pat[c]}) begin
                bad++;
                $display("FAIL burst_beat_c%0d: mem_r_valid=%b mem_r_data=%h mem_r_last=%b r_ready=%b want 1 %h %b %b",
                         c, mem_r_valid, mem_r_data, mem_r_last, r_ready, beat_data[k], (k == 3), rdy_pat[c]);
            end
            if (!(busy === 1'b1 && if_ar_ready === 1'b0 && if_r_valid === 1'b0)) held_bad++;
            if (mem_r_valid === 1'b1 && mem_r_ready === 1'b1) delivered++;
            if (rdy_pat[c]) k++;
        end
        total++;
        if (delivered !== 4) begin
            bad++; $display("FAIL burst_beat_count: got %0d want 4", delivered);
        end
        total++;
        if (held_bad !== 0) begin
            bad++; $display("FAIL burst_if_held_off: %0d cycles with IF not held or not busy, want 0", held_bad);
        end
        @(negedge clk);
        r_valid = 1'b0; r_last = 1'b0; mem_r_ready = 1'b0; r_resp = RESP_OKAY;
        #1;
        total++;
        if ({busy, mem_r_valid} !== 2'b00) begin
            bad++; $display("FAIL burst_end_idle: busy,mem_r_valid=%b want 00", {busy, mem_r_valid});
        end
        @(negedge clk); #1;
        total++;
        if ({ar_valid, ar_addr} !== {1'b1, 64'h4000}) begin
            bad++; $display("FAIL burst_then_if: ar_valid=%b ar_addr=%h want 1 4000", ar_valid, ar_addr);
        end
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0; if_ar_valid = 1'b0;
        r_valid = 1'b1; r_last = 1'b1; r_data = 64'h44; if_r_ready = 1'b1;
        @(negedge clk);
        r_valid = 1'b0; r_last = 1'b0; if_r_ready = 1'b0;
    endtask

    task automatic test_slverr();
        @(negedge clk);
        if_ar_valid = 1'b1; if_ar_addr = 64'h5000; if_ar_len = 8'd1;
        @(negedge clk);
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0; if_ar_valid = 1'b0;
        r_valid = 1'b1; r_data = 64'h50; r_resp = RESP_DECERR; r_last = 1'b0; if_r_ready = 1'b1;
        #1;
        total++;
        if ({if_r_valid, if_r_resp, if_r_last} !== {1'b1, 2'b11, 1'b0}) begin
            bad++; $display("FAIL err_decerr_beat0: valid=%b resp=%b last=%b want 1 11 0", if_r_valid, if_r_resp, if_r_last);
        end
        @(negedge clk);
        r_data = 64'h51; r_resp = RESP_SLVERR; r_last = 1'b1;
        #1;
        total++;
        if ({if_r_valid, if_r_resp, if_r_last, busy} !== {1'b1, 2'b10, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL err_slverr_last: valid=%b resp=%b last=%b busy=%b want 1 10 1 1", if_r_valid, if_r_resp, if_r_last, busy);
        end
        @(negedge clk);
        r_valid = 1'b0; r_last = 1'b0; r_resp = RESP_OKAY; if_r_ready = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL err_back_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_mid_burst_reset();
        @(negedge clk);
        mem_ar_valid = 1'b1; mem_ar_addr = 64'h6000; mem_ar_len = 8'd7;
        @(negedge clk);
        ar_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            ar_ready = 1'b0; mem_ar_valid = 1'b0;
            r_valid = 1'b1; r_data = 64'h60 + 64'(b); r_last = 1'b0; mem_r_ready = 1'b1;
        end
        #1;
        total++;
        if ({mem_r_valid, mem_r_data, busy} !== {1'b1, 64'h62, 1'b1}) begin
            bad++; $display("FAIL rst_pre_beat2: mem_r_valid=%b mem_r_data=%h busy=%b want 1 62 1", mem_r_valid, mem_r_data, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ar_valid, if_ar_ready, mem_ar_ready, if_r_valid, mem_r_valid, r_ready, busy} !== 7'b0) begin
            bad++;
            $display("FAIL rst_async_drop: got %b want 0000000",
                     {ar_valid, if_ar_ready, mem_ar_ready, if_r_valid, mem_r_valid, r_ready, busy});
        end
        @(negedge clk);
        r_valid = 1'b0; r_data = '0; mem_r_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        if_ar_valid = 1'b1; if_ar_addr = 64'h7000; if_ar_len = 8'd0;
        @(negedge clk); #1;
        total++;
        if ({ar_valid, ar_addr} !== {1'b1, 64'h7000}) begin
            bad++; $display("FAIL rst_after_grant: ar_valid=%b ar_addr=%h want 1 7000", ar_valid, ar_addr);
        end
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0; if_ar_valid = 1'b0;
        r_valid = 1'b1; r_data = 64'hDEAD_BEEF; r_last = 1'b1; if_r_ready = 1'b1;
        #1;
        total++;
        if ({if_r_valid, if_r_data, if_r_last} !== {1'b1, 64'hDEAD_BEEF, 1'b1}) begin
            bad++; $display("FAIL rst_after_beat: if_r_valid=%b if_r_data=%h if_r_last=%b want 1 deadbeef 1", if_r_valid, if_r_data, if_r_last);
        end
        @(negedge clk);
        r_valid = 1'b0; r_last = 1'b0; if_r_ready = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_after_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_streak();
        logic exp_mem;
        logic found;
        @(negedge clk);
        if_ar_valid  = 1'b1; if_ar_addr  = 64'hA000; if_ar_len  = 8'd0;
        mem_ar_valid = 1'b1; mem_ar_addr = 64'hB000; mem_ar_len = 8'd0;
        if_r_ready = 1'b1; mem_r_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_mem = ((i % 5) != 4);
            found = 1'b0;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk); #1;
                if (ar_valid === 1'b1) begin
                    found = 1'b1;
                    break;
                end
            end
            total++;
            if (found !== 1'b1) begin
                bad++; $display("FAIL streak_wait_grant_%0d: ar_valid=%b want 1 within 8 cycles", i, ar_valid);
                break;
            end
            ar_ready = 1'b1;
            #1;
            total++;
            if ({if_ar_ready, mem_ar_ready} !== (exp_mem ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL streak_grant_%0d: if,mem ar_ready=%b want %b", i, {if_ar_ready, mem_ar_ready}, (exp_mem ? 2'b01 : 2'b10));
            end
            @(negedge clk);
            ar_ready = 1'b0;
            r_valid = 1'b1; r_last = 1'b1; r_data = 64'(i);
            #1;
            total++;
            if ({if_r_valid, mem_r_valid} !== (exp_mem ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL streak_beat_%0d: if,mem r_valid=%b want %b", i, {if_r_valid, mem_r_valid}, (exp_mem ? 2'b01 : 2'b10));
            end
            @(negedge clk);
            r_valid = 1'b0; r_last = 1'b0;
        end
        if_ar_valid = 1'b0; mem_ar_valid = 1'b0;
        @(negedge clk);
        if_r_ready = 1'b0; mem_r_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_if();
        test_both_same_cycle();
        test_mem_burst();
        test_slverr();
        test_mid_burst_reset();
        test_streak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
